// File: rtl/euler_result_writer_pkg.sv
// Shared types and default widths for the Euler accelerator blocks.
// Imported by the pipeline, join and write-back stages.
package euler_result_writer_pkg;

  localparam int ADD_SIZE_DEF  = 16;
  localparam int DATA_SIZE_DEF = 16;
  localparam int DEPTH_DEF     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/euler_result_writer_fifo.sv
// Synchronous FIFO for pending result writes.
// Push into a full FIFO is allowed when a pop happens in the same cycle.
module result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/euler_result_writer.sv
// Write-back stage: buffers join-pipe results and writes them to the
// result memory; drained means every result has actually been written.
import euler_result_writer_pkg::*;

module euler_result_writer #(
  parameter int ADD_SIZE  = ADD_SIZE_DEF,
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int DEPTH     = DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 finish,
  input  logic                 res_valid,
  input  logic [DATA_SIZE-1:0] res_data,
  input  logic [ADD_SIZE-1:0]  res_addr,
  input  logic [ADD_SIZE-1:0]  base_addr,
  output logic                 mem_we,
  output logic [ADD_SIZE-1:0]  mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  input  logic                 mem_ready,
  output logic                 busy,
  output logic                 drained,
  output logic                 drop_err
);

  localparam int W  = ADD_SIZE + DATA_SIZE;
  localparam int CW = $clog2(DEPTH) + 1;

  state_t               state;
  state_t               state_n;
  logic [ADD_SIZE-1:0]  base_q;
  logic [ADD_SIZE-1:0]  wr_addr;
  logic [W-1:0]         fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic                 active;
  logic                 start_ok;
  logic                 out_free;
  logic                 fifo_pop;
  logic                 fifo_push;
  logic                 accept;
  logic                 bypass;
  logic                 drop;
  logic                 drain_done;

  assign active   = (state == RUN) || (state == DRAIN);
  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign out_free = !mem_we || mem_ready;
  assign fifo_pop = out_free && !fifo_empty;
  assign accept   = active && res_valid && (!fifo_full || fifo_pop);
  assign drop     = active && res_valid && !accept;
  assign wr_addr  = base_q + res_addr;

  // An empty FIFO with a free output register skips the FIFO entirely.
  assign bypass    = accept && out_free && fifo_empty;
  assign fifo_push = accept && !bypass;

  assign drain_done = (fifo_count == '0) && !accept && out_free;

  result_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({wr_addr, res_data}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start) state_n = RUN;
      RUN:   if (finish) state_n = DRAIN;
      DRAIN: if (drain_done) state_n = DONE;
      DONE:  if (start) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      drained  <= 1'b0;
      base_q   <= '0;
      drop_err <= 1'b0;
    end else begin
      state   <= state_n;
      busy    <= (state_n == RUN) || (state_n == DRAIN);
      drained <= (state_n == DONE);
      if (start_ok) begin
        base_q   <= base_addr;
        drop_err <= 1'b0;
      end else if (drop) begin
        drop_err <= 1'b1;
      end
    end
  end

  // Output register only reloads when empty or handshaking, so it holds
  // address and data steady under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (start_ok) begin
      mem_we <= 1'b0;
    end else if (fifo_pop) begin
      mem_we    <= 1'b1;
      mem_addr  <= fifo_rdata[W-1:DATA_SIZE];
      mem_wdata <= fifo_rdata[DATA_SIZE-1:0];
    end else if (bypass) begin
      mem_we    <= 1'b1;
      mem_addr  <= wr_addr;
      mem_wdata <= res_data;
    end else if (out_free) begin
      mem_we <= 1'b0;
    end
  end

endmodule

// File: doc/euler_result_writer.md
# euler_result_writer

Write-back stage for the Euler accelerator. It takes the result stream produced by the join pipe (a strobe plus a data word and a destination address per computed element), buffers it in a small FIFO, and issues the writes to a single-port result memory using a valid/ready handshake. Its state machine tracks the accelerator's finish signal, so "drained" means every result has actually reached memory and not merely been computed.

## Interface
Parameters:
- ADD_SIZE, 16, address width
- DATA_SIZE, 16, data word width
- DEPTH, 4, FIFO entries; power of two, 2..16

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a new run; same pulse that starts the pipelines
- finish  in  1  accelerator finished; no further results will arrive
- res_valid  in  1  result strobe, one cycle per result
- res_data  in  DATA_SIZE  result word
- res_addr  in  ADD_SIZE  result address, relative to base_addr
- base_addr  in  ADD_SIZE  result region base; sampled on start
- mem_we  out  1  write request valid
- mem_addr  out  ADD_SIZE  write address
- mem_wdata  out  DATA_SIZE  write data
- mem_ready  in  1  memory accepts the write this cycle
- busy  out  1  state is RUN or DRAIN
- drained  out  1  all results written after finish
- drop_err  out  1  sticky: a result arrived while the FIFO was full

## Operation
- States and transitions:
  - IDLE: go to RUN on start.
  - RUN: go to DRAIN on finish.
  - DRAIN: go to DONE when the FIFO is empty and no write is outstanding.
  - DONE: go to RUN on start.
  - A start seen in RUN or DRAIN is ignored.
- On start, base_addr is latched, the FIFO is cleared and drop_err is cleared.
- Enqueue:
  - Accepted only in RUN or DRAIN, when res_valid=1 and the FIFO is not full.
  - A pop in the same cycle counts as making room, so a push to a full FIFO with a simultaneous pop is accepted.
  - The stored address is base_addr + res_addr, truncated to ADD_SIZE bits (wrap-around, no error).
- Drop:
  - res_valid while full with no simultaneous pop discards the result and sets drop_err=1.
  - drop_err stays set until the next start or rst.
  - res_valid in IDLE or DONE is ignored and does not set drop_err.
- Write port:
  - mem_we=1 whenever the output register holds an entry.
  - mem_addr and mem_wdata must stay stable while mem_we=1 and mem_ready=0.
  - The write completes on a cycle where mem_we & mem_ready; the next FIFO entry, if any, loads in that same cycle.
- A finish that arrives in the same cycle as the last res_valid still enqueues that result before DRAIN starts.
- FIFO occupancy counter is clog2(DEPTH)+1 bits. The output register is separate from the DEPTH entries.

## Timing
- Reset values:
  - State IDLE.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - busy=0, drained=0, drop_err=0.
  - FIFO empty.
- rst in the middle of a run discards all buffered and outstanding writes. mem_we drops the cycle after rst.
- Latency: res_valid at cycle N into an empty FIFO gives mem_we=1 at cycle N+1.
- Throughput: one write per cycle when mem_ready is held at 1.
- drained goes to 1 on the cycle after the final handshake, and stays 1 until start or rst.
- busy is registered and follows the state transitions with one cycle of latency.

## Structure
- Shared package:
  - State encoding: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3.
  - The default widths ADD_SIZE, DATA_SIZE and DEPTH, shared with the pipeline and join blocks.
- One sub-module, result_fifo: synchronous FIFO with parameterised width and depth, push/pop/full/empty/count, and a clear input. The FIFO width is ADD_SIZE+DATA_SIZE (address and data stored together).
- The top level contains the state machine, the address adder, the output register and the sticky error flag.
- Expected size is roughly 200 lines of RTL.

## Test plan
- Basic write:
  - Stimulus: base_addr=0x0100, start; res_valid with addr 0x0002, data 0x1234; mem_ready=1.
  - Response: mem_we at the next cycle with mem_addr=0x0102 and mem_wdata=0x1234.
- Backpressure:
  - Stimulus: mem_ready=0; push 5 results with DEPTH=4.
  - Response: 4 in the FIFO plus 1 in the output register, no drop. The output stays stable. After mem_ready=1, writes come out in order on 5 consecutive cycles.
- Overflow:
  - Stimulus: mem_ready=0; push 6 results.
  - Response: the 6th is dropped and drop_err=1. Only 5 writes come out. The next start clears drop_err to 0.
- Finish drain:
  - Stimulus: finish in the same cycle as the 3rd result, with mem_ready toggling 1/0.
  - Response: all 3 written; drained=1 the cycle after the 3rd handshake; busy=0.
- Address wrap:
  - Stimulus: base_addr=0xFFFE, res_addr=0x0003.
  - Response: mem_addr=0x0001, drop_err=0.
- Reset mid-run:
  - Stimulus: rst with 3 entries buffered and mem_ready=0.
  - Response: the next cycle shows mem_we=0, state IDLE, and no writes after rst is released.
